axi_lite_arbiter: RTL and testbench

Round-robin arbiter that lets `NUM_MASTERS` AXI4-Lite masters share one AXI4-Lite slave port. It sits between the master-side `axi_lite_if` instances and the downstream slave, such as `axi_lite_slave`. It allows one complete transaction (read or write) in flight at a time. The grant is locked from the address handshake through the response handshake.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_if.sv | 32 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/axi_lite_arbiter.sv | 113 +++++++++++
 tb/tb_axi_lite_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and the arbiter state encoding.
package axi_lite_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW   = 3'd3,
    W    = 3'd4,
    B    = 3'd5
  } arb_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle with master and slave views; all users share one clock.
interface axi_lite_if;

  logic [axi_lite_pkg::ADDR_WIDTH-1:0] awaddr;
  logic                                awvalid;
  logic                                awready;
  logic [axi_lite_pkg::DATA_WIDTH-1:0] wdata;
  logic [axi_lite_pkg::STRB_WIDTH-1:0] wstrb;
  logic                                wvalid;
  logic                                wready;
  logic [1:0]                          bresp;
  logic                                bvalid;
  logic                                bready;
  logic [axi_lite_pkg::ADDR_WIDTH-1:0] araddr;
  logic                                arvalid;
  logic                                arready;
  logic [axi_lite_pkg::DATA_WIDTH-1:0] rdata;
  logic [1:0]                          rresp;
  logic                                rvalid;
  logic                                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   gnt_valid
);

  localparam logic [IDX_W:0] NM = (IDX_W+1)'(NUM_MASTERS);

  // One extra bit so last_grant + k never overflows before the modulo fold.
  logic [IDX_W:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= NM) cand = cand - NM;
      if (!gnt_valid && req[cand[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Round-robin AXI4-Lite N:1 arbiter; one transaction in flight, grant locked
// from address handshake to response handshake, purely combinational forwarding.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             rst,
  axi_lite_if.slave        s_axi_lite [NUM_MASTERS],
  axi_lite_if.master       m_axi_lite,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);

  arb_state_t state, state_next;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             load_grant;

  logic [NUM_MASTERS-1:0] arvalid_vec, awvalid_vec, wvalid_vec, rready_vec, bready_vec;
  logic [NUM_MASTERS-1:0] req;
  logic [ADDR_WIDTH-1:0]  araddr_vec [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  awaddr_vec [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  wdata_vec  [NUM_MASTERS];
  logic [STRB_WIDTH-1:0]  wstrb_vec  [NUM_MASTERS];

  // Flatten the interface array so the granted master can be picked by index;
  // responses reach only the granted master and only in the matching state.
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_port
    logic sel;
    assign sel = (grant_idx == IDX_W'(g));

    assign arvalid_vec[g] = s_axi_lite[g].arvalid;
    assign awvalid_vec[g] = s_axi_lite[g].awvalid;
    assign wvalid_vec[g]  = s_axi_lite[g].wvalid;
    assign rready_vec[g]  = s_axi_lite[g].rready;
    assign bready_vec[g]  = s_axi_lite[g].bready;
    assign araddr_vec[g]  = s_axi_lite[g].araddr;
    assign awaddr_vec[g]  = s_axi_lite[g].awaddr;
    assign wdata_vec[g]   = s_axi_lite[g].wdata;
    assign wstrb_vec[g]   = s_axi_lite[g].wstrb;

    assign s_axi_lite[g].arready = sel && (state == AR) && m_axi_lite.arready;
    assign s_axi_lite[g].awready = sel && (state == AW) && m_axi_lite.awready;
    assign s_axi_lite[g].wready  = sel && (state == W)  && m_axi_lite.wready;
    assign s_axi_lite[g].rvalid  = sel && (state == R)  && m_axi_lite.rvalid;
    assign s_axi_lite[g].bvalid  = sel && (state == B)  && m_axi_lite.bvalid;
    assign s_axi_lite[g].rdata   = (sel && state == R) ? m_axi_lite.rdata : '0;
    assign s_axi_lite[g].rresp   = (sel && state == R) ? m_axi_lite.rresp : RESP_OKAY;
    assign s_axi_lite[g].bresp   = (sel && state == B) ? m_axi_lite.bresp : RESP_OKAY;
  end

  assign req = arvalid_vec | awvalid_vec;

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_rr (
    .req       (req),
    .last_grant(last_grant),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign m_axi_lite.araddr  = araddr_vec[grant_idx];
  assign m_axi_lite.arvalid = (state == AR) && arvalid_vec[grant_idx];
  assign m_axi_lite.rready  = (state == R)  && rready_vec[grant_idx];
  assign m_axi_lite.awaddr  = awaddr_vec[grant_idx];
  assign m_axi_lite.awvalid = (state == AW) && awvalid_vec[grant_idx];
  assign m_axi_lite.wdata   = wdata_vec[grant_idx];
  assign m_axi_lite.wstrb   = wstrb_vec[grant_idx];
  assign m_axi_lite.wvalid  = (state == W)  && wvalid_vec[grant_idx];
  assign m_axi_lite.bready  = (state == B)  && bready_vec[grant_idx];

  assign busy = (state != IDLE);

  // Read is preferred when the winner has both address channels raised.
  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    unique case (state)
      IDLE: if (gnt_valid) begin
        load_grant = 1'b1;
        state_next = arvalid_vec[gnt_idx] ? AR : AW;
      end
      AR: if (m_axi_lite.arvalid && m_axi_lite.arready) state_next = R;
      R:  if (m_axi_lite.rvalid  && m_axi_lite.rready)  state_next = IDLE;
      AW: if (m_axi_lite.awvalid && m_axi_lite.awready) state_next = W;
      W:  if (m_axi_lite.wvalid  && m_axi_lite.wready)  state_next = B;
      B:  if (m_axi_lite.bvalid  && m_axi_lite.bready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // last_grant resets to the top index so master 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state <= state_next;
      if (load_grant) begin
        grant_idx  <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: directed masters, a behavioural slave
// with programmable delays, and a negedge monitor popping expected responses.
module tb_axi_lite_arbiter;
  import axi_lite_pkg::*;

  localparam int N = 2;
  localparam int S_IDLE = 0, S_AR = 1, S_R = 2, S_AW = 3, S_W = 4, S_B = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_if s_if [N] ();
  axi_lite_if m_if ();

  logic [$clog2(N)-1:0] grant_idx;
  logic                 busy;

  axi_lite_arbiter #(.NUM_MASTERS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi_lite(s_if),
    .m_axi_lite(m_if),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  // Master-side stimulus and observation
  logic [N-1:0] arvalid = '0, awvalid = '0, wvalid = '0, rready = '1, bready = '1;
  logic [31:0]  araddr [N];
  logic [31:0]  awaddr [N];
  logic [31:0]  wdata  [N];
  logic [3:0]   wstrb  [N];
  logic [N-1:0] arready_o, awready_o, wready_o, rvalid_o, bvalid_o;
  logic [31:0]  rdata_o [N];
  logic [1:0]   rresp_o [N];
  logic [1:0]   bresp_o [N];
  logic [N-1:0] ar_hs, aw_hs, w_hs;

  for (genvar g = 0; g < N; g++) begin : g_m
    assign s_if[g].arvalid = arvalid[g];
    assign s_if[g].araddr  = araddr[g];
    assign s_if[g].awvalid = awvalid[g];
    assign s_if[g].awaddr  = awaddr[g];
    assign s_if[g].wvalid  = wvalid[g];
    assign s_if[g].wdata   = wdata[g];
    assign s_if[g].wstrb   = wstrb[g];
    assign s_if[g].rready  = rready[g];
    assign s_if[g].bready  = bready[g];
    assign arready_o[g] = s_if[g].arready;
    assign awready_o[g] = s_if[g].awready;
    assign wready_o[g]  = s_if[g].wready;
    assign rvalid_o[g]  = s_if[g].rvalid;
    assign bvalid_o[g]  = s_if[g].bvalid;
    assign rdata_o[g]   = s_if[g].rdata;
    assign rresp_o[g]   = s_if[g].rresp;
    assign bresp_o[g]   = s_if[g].bresp;
  end

  typedef struct {
    int          mst;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t exp_q[$];

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Slave model: memory-backed, delays counted in cycles before ready/valid
  logic [31:0] mem [16];
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;

  initial begin
    int sst, cnt;
    bit h_ar, h_r, h_aw, h_w, h_b;
    logic [31:0] rd_addr, wr_addr, wr_data;
    sst = S_IDLE; cnt = 0;
    h_ar = 0; h_r = 0; h_aw = 0; h_w = 0; h_b = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    m_if.arready = 1'b0; m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.rvalid = 1'b0; m_if.bvalid = 1'b0; m_if.rdata = '0;
    m_if.rresp = RESP_OKAY; m_if.bresp = RESP_OKAY;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        m_if.arready = 1'b0; m_if.awready = 1'b0; m_if.wready = 1'b0;
        m_if.rvalid = 1'b0; m_if.bvalid = 1'b0;
        sst = S_IDLE;
        h_ar = 0; h_r = 0; h_aw = 0; h_w = 0; h_b = 0;
      end else begin
        if (h_ar) begin m_if.arready = 1'b0; sst = S_R; cnt = r_dly; end
        if (h_r)  begin m_if.rvalid = 1'b0; sst = S_IDLE; end
        if (h_aw) begin m_if.awready = 1'b0; sst = S_W; cnt = w_dly; end
        if (h_w)  begin m_if.wready = 1'b0; mem[wr_addr[5:2]] = wr_data; sst = S_B; cnt = b_dly; end
        if (h_b)  begin m_if.bvalid = 1'b0; sst = S_IDLE; end
        if (sst == S_IDLE) begin
          if (m_if.arvalid) begin sst = S_AR; cnt = ar_dly; end
          else if (m_if.awvalid) begin sst = S_AW; cnt = aw_dly; end
        end
        case (sst)
          S_AR: if (cnt == 0) m_if.arready = 1'b1; else cnt--;
          S_R:  if (cnt == 0) begin
                  m_if.rvalid = 1'b1; m_if.rdata = mem[rd_addr[5:2]]; m_if.rresp = RESP_OKAY;
                end else cnt--;
          S_AW: if (cnt == 0) m_if.awready = 1'b1; else cnt--;
          S_W:  if (cnt == 0) m_if.wready = 1'b1; else cnt--;
          S_B:  if (cnt == 0) begin m_if.bvalid = 1'b1; m_if.bresp = RESP_OKAY; end else cnt--;
          default: ;
        endcase
        h_ar = m_if.arvalid && m_if.arready;
        h_r  = m_if.rvalid  && m_if.rready;
        h_aw = m_if.awvalid && m_if.awready;
        h_w  = m_if.wvalid  && m_if.wready;
        h_b  = m_if.bvalid  && m_if.bready;
        if (h_ar) rd_addr = m_if.araddr;
        if (h_aw) wr_addr = m_if.awaddr;
        if (h_w)  wr_data = m_if.wdata;
      end
    end
  end

  // Monitor: downstream address/data against the head transaction, and
  // upstream responses pop and retire it.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_if.arvalid && m_if.arready) begin
          if (exp_q.size() == 0) fail_now("unexpected_ar");
          else check("ar_addr", m_if.araddr, exp_q[0].addr);
        end
        if (m_if.awvalid && m_if.awready) begin
          if (exp_q.size() == 0) fail_now("unexpected_aw");
          else check("aw_addr", m_if.awaddr, exp_q[0].addr);
        end
        if (m_if.wvalid && m_if.wready) begin
          if (exp_q.size() == 0) fail_now("unexpected_w");
          else check("w_data", m_if.wdata, exp_q[0].data);
        end
        for (int i = 0; i < N; i++) begin
          if (rvalid_o[i] && rready[i]) begin
            if (exp_q.size() == 0) fail_now("unexpected_r");
            else begin
              t = exp_q.pop_front();
              check("r_master", 32'(i), 32'(t.mst));
              check("r_is_read", 32'(t.rd), 32'd1);
              check("r_data", rdata_o[i], t.data);
              check("r_resp", 32'(rresp_o[i]), 32'(RESP_OKAY));
              check("r_grant", 32'(grant_idx), 32'(i));
            end
          end
          if (bvalid_o[i] && bready[i]) begin
            if (exp_q.size() == 0) fail_now("unexpected_b");
            else begin
              t = exp_q.pop_front();
              check("b_master", 32'(i), 32'(t.mst));
              check("b_is_write", 32'(t.rd), 32'd0);
              check("b_resp", 32'(bresp_o[i]), 32'(RESP_OKAY));
            end
          end
        end
      end
    end
  end

  // One clock: note which address/data valids were accepted, then drop them.
  task automatic step();
    @(negedge clk);
    ar_hs = arvalid & arready_o;
    aw_hs = awvalid & awready_o;
    w_hs  = wvalid  & wready_o;
    @(posedge clk); #1;
    arvalid = arvalid & ~ar_hs;
    awvalid = awvalid & ~aw_hs;
    wvalid  = wvalid  & ~w_hs;
  endtask

  task automatic check_all_quiet(input string name);
    for (int i = 0; i < N; i++) begin
      check({name, "_up_handshake"},
            32'({arready_o[i], awready_o[i], wready_o[i], rvalid_o[i], bvalid_o[i]}), 32'd0);
      check({name, "_up_rdata"}, rdata_o[i], 32'd0);
    end
    check({name, "_down_valid"},
          32'({m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready}), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_grant"}, 32'(grant_idx), 32'd0);
  endtask

  // Runs one granted transaction to IDLE, checking grant lock and isolation.
  task automatic run_txn(input string name, input int g, input int exp_busy);
    int nb = 0;
    bit seen = 0, done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      if (busy) begin
        seen = 1;
        nb++;
        check({name, "_grant"}, 32'(grant_idx), 32'(g));
        for (int i = 0; i < N; i++) begin
          if (i != g) begin
            check({name, "_blocked"},
                  32'({arready_o[i], awready_o[i], wready_o[i], rvalid_o[i], bvalid_o[i]}), 32'd0);
            check({name, "_blocked_rdata"}, rdata_o[i], 32'd0);
          end
        end
        if (m_if.awvalid) check({name, "_early_w"}, 32'({wready_o[g], m_if.wvalid}), 32'd0);
      end else if (seen) begin
        done = 1;
      end
    end
    if (!done) fail_now({name, "_timeout"});
    else check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  task automatic push(input int mst, input bit rd, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.mst = mst; t.rd = rd; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = 32'h3333_000C;
    mem[4] = 32'h1111_0010;
    mem[5] = 32'h4444_0014;
    mem[8] = 32'h2222_0020;
    for (int i = 0; i < N; i++) begin
      araddr[i] = '0; awaddr[i] = '0; wdata[i] = '0; wstrb[i] = 4'hF;
    end

    // Reset with requests pending: outputs must stay idle
    rst = 1'b1;
    arvalid[0] = 1'b1; awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_quiet("reset");
    arvalid = '0; awvalid = '0; wvalid = '0;
    rst = 1'b0;
    step();

    // Single read by master 1
    push(1, 1, 32'h0000_0008, 32'hDEAD_BEEF);
    araddr[1] = 32'h0000_0008; arvalid[1] = 1'b1;
    run_txn("rd1", 1, 2);

    // Contention, two rounds: 0,1 then 0,1 again
    push(0, 1, 32'h10, 32'h1111_0010);
    push(1, 1, 32'h20, 32'h2222_0020);
    araddr[0] = 32'h10; araddr[1] = 32'h20; arvalid = 2'b11;
    run_txn("cont_a0", 0, 2);
    run_txn("cont_a1", 1, 2);
    step();
    push(0, 1, 32'h0C, 32'h3333_000C);
    push(1, 1, 32'h14, 32'h4444_0014);
    araddr[0] = 32'h0C; araddr[1] = 32'h14; arvalid = 2'b11;
    run_txn("cont_b0", 0, 2);
    run_txn("cont_b1", 1, 2);

    // Write with W raised together with AW, then read it back
    push(0, 0, 32'h4, 32'h0000_1234);
    awaddr[0] = 32'h4; wdata[0] = 32'h0000_1234; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    run_txn("wr0", 0, 3);
    push(0, 1, 32'h4, 32'h0000_1234);
    araddr[0] = 32'h4; arvalid[0] = 1'b1;
    run_txn("rb0", 0, 2);

    // Master 1 read+write together, master 0 also reading
    push(1, 1, 32'h08, 32'hDEAD_BEEF);
    push(0, 1, 32'h10, 32'h1111_0010);
    push(1, 0, 32'h18, 32'h5555_AAAA);
    araddr[1] = 32'h08; awaddr[1] = 32'h18; wdata[1] = 32'h5555_AAAA;
    araddr[0] = 32'h10;
    arvalid = 2'b11; awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    run_txn("rw_m1rd", 1, 2);
    run_txn("rw_m0rd", 0, 2);
    run_txn("rw_m1wr", 1, 3);

    // Downstream backpressure: arready held 5 cycles, rvalid 3 cycles late
    ar_dly = 5; r_dly = 3;
    push(0, 1, 32'h20, 32'h2222_0020);
    push(1, 1, 32'h0C, 32'h3333_000C);
    araddr[0] = 32'h20; araddr[1] = 32'h0C; arvalid = 2'b11;
    run_txn("bp_m0", 0, 10);
    ar_dly = 0; r_dly = 0;
    run_txn("bp_m1", 1, 2);

    // Reset while the write sits in W
    w_dly = 20;
    push(0, 0, 32'h1C, 32'hCAFE_F00D);
    awaddr[0] = 32'h1C; wdata[0] = 32'hCAFE_F00D;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (m_if.wvalid) found = 1;
    end
    if (!found) fail_now("reach_w_state");
    step();
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_quiet("mid_reset");
    wvalid = '0; awvalid = '0;
    exp_q.delete();
    rst = 1'b0;
    w_dly = 0;
    step();

    // First post-reset arbitration starts from master 0
    push(0, 1, 32'h08, 32'hDEAD_BEEF);
    push(1, 1, 32'h10, 32'h1111_0010);
    araddr[0] = 32'h08; araddr[1] = 32'h10; arvalid = 2'b11;
    run_txn("post_m0", 0, 2);
    run_txn("post_m1", 1, 2);

    step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
